// File: rtl/german_rule_sched.sv
// german_rule_sched: round-robin rule scheduler with budget, stop and deadlock detection
module german_rule_sched #(
    parameter int NRULES   = 24,
    parameter int DL_LIMIT = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    input  logic              io_stop,
    input  logic [15:0]       io_budget,
    input  logic [NRULES-1:0] io_guard,
    output logic [4:0]        io_en_a,
    output logic              io_fire,
    output logic [1:0]        io_state,
    output logic [15:0]       io_steps,
    output logic              io_deadlock
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] HALT = 2'd2;
    localparam logic [1:0] DEAD = 2'd3;
    localparam logic [4:0] NOP  = 5'd31;

    logic [1:0]  state;
    logic [4:0]  ptr;
    logic [7:0]  idle_cnt;
    logic [15:0] budget_reg;
    logic [15:0] steps_next;
    logic [63:0] guard_ext;
    logic [5:0]  sum;
    logic [5:0]  idx;
    logic [4:0]  sel;
    logic        init;

    assign guard_ext = 64'(io_guard);

    always_comb begin
        sel = NOP;
        sum = '0;
        idx = '0;
        for (int k = NRULES; k >= 1; k--) begin
            sum = {1'b0, ptr} + 6'(k);
            idx = (sum >= 6'(NRULES)) ? sum - 6'(NRULES) : sum;
            if (guard_ext[idx]) sel = idx[4:0];
        end
    end

    assign io_en_a    = (state == RUN) ? sel : NOP;
    assign io_fire    = (state == RUN) && (sel != NOP);
    assign io_state   = state;
    assign steps_next = (io_steps == 16'hFFFF) ? io_steps : io_steps + 16'd1;
    assign init       = io_start && ((state == HALT) || (state == DEAD) || (state == IDLE && !io_stop));

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 5'(NRULES - 1);
            io_steps    <= '0;
            idle_cnt    <= '0;
            budget_reg  <= '0;
            io_deadlock <= 1'b0;
        end else if (init) begin
            state       <= RUN;
            ptr         <= 5'(NRULES - 1);
            io_steps    <= '0;
            idle_cnt    <= '0;
            budget_reg  <= io_budget;
            io_deadlock <= 1'b0;
        end else if (state == RUN) begin
            if (io_fire) begin
                ptr      <= io_en_a;
                io_steps <= steps_next;
                idle_cnt <= '0;
            end else begin
                idle_cnt <= (idle_cnt == 8'hFF) ? idle_cnt : idle_cnt + 8'd1;
            end
            if (io_stop || (io_fire && budget_reg != 16'd0 && steps_next == budget_reg)) begin
                state <= HALT;
            end else if (!io_fire && idle_cnt == 8'(DL_LIMIT - 1)) begin
                state       <= DEAD;
                io_deadlock <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_german_rule_sched.sv
// tb_german_rule_sched: directed checks of scheduling, budget, stop, deadlock and reset
module tb_german_rule_sched;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_start = 1'b0;
    logic        io_stop = 1'b0;
    logic [15:0] io_budget = '0;
    logic [23:0] io_guard = '0;
    logic [4:0]  io_en_a;
    logic        io_fire;
    logic [1:0]  io_state;
    logic [15:0] io_steps;
    logic        io_deadlock;
    int          errors = 0;
    int          checks = 0;

    german_rule_sched dut (
        .clock(clock), .reset(reset), .io_start(io_start), .io_stop(io_stop),
        .io_budget(io_budget), .io_guard(io_guard), .io_en_a(io_en_a), .io_fire(io_fire),
        .io_state(io_state), .io_steps(io_steps), .io_deadlock(io_deadlock)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int seq[5];
        seq = '{3, 7, 20, 3, 7};
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("idle_state", 32'(io_state), 0);
            chk("idle_en_a", 32'(io_en_a), 31);
            chk("idle_fire", 32'(io_fire), 0);
            chk("idle_steps", 32'(io_steps), 0);
        end

        io_start = 1'b1;
        io_stop = 1'b1;
        tick();
        io_start = 1'b0;
        io_stop = 1'b0;
        chk("start_stop_idle", 32'(io_state), 0);

        io_guard = 24'(1 << 3) | 24'(1 << 7) | 24'(1 << 20);
        io_budget = 16'd0;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        chk("run_state", 32'(io_state), 1);
        for (int i = 0; i < 5; i++) begin
            chk("rr_en_a", 32'(io_en_a), 32'(seq[i]));
            chk("rr_fire", 32'(io_fire), 1);
            tick();
        end
        chk("rr_steps5", 32'(io_steps), 5);
        io_start = 1'b1;
        #1;
        chk("start_in_run_en_a", 32'(io_en_a), 20);
        tick();
        io_start = 1'b0;
        chk("start_in_run_ignored", 32'(io_steps), 6);
        chk("start_in_run_state", 32'(io_state), 1);

        io_guard = '1;
        io_budget = 16'd2;
        io_stop = 1'b1;
        tick();
        io_stop = 1'b0;
        chk("stop_halt", 32'(io_state), 2);
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        chk("budget_grant0", 32'(io_en_a), 0);
        tick();
        chk("budget_grant1", 32'(io_en_a), 1);
        chk("budget_state_run", 32'(io_state), 1);
        tick();
        chk("budget_halt", 32'(io_state), 2);
        chk("budget_steps", 32'(io_steps), 2);
        chk("halt_en_a", 32'(io_en_a), 31);
        chk("halt_fire", 32'(io_fire), 0);

        io_guard = '0;
        io_budget = 16'd0;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        chk("dl_nop_en_a", 32'(io_en_a), 31);
        chk("dl_nop_fire", 32'(io_fire), 0);
        for (int i = 0; i < 14; i++) tick();
        chk("dl_before", 32'(io_state), 1);
        tick();
        chk("dl_state", 32'(io_state), 3);
        chk("dl_flag", 32'(io_deadlock), 1);
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        chk("dl_restart_state", 32'(io_state), 1);
        chk("dl_restart_flag", 32'(io_deadlock), 0);

        io_guard = 24'(1 << 5);
        #1;
        chk("stop_fire_en_a", 32'(io_en_a), 5);
        io_stop = 1'b1;
        tick();
        io_stop = 1'b0;
        chk("stop_fire_state", 32'(io_state), 2);
        chk("stop_fire_steps", 32'(io_steps), 1);

        io_guard = '0;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        chk("stop_dl_before", 32'(io_state), 1);
        io_stop = 1'b1;
        tick();
        io_stop = 1'b0;
        chk("stop_over_dl", 32'(io_state), 2);
        chk("stop_over_dl_flag", 32'(io_deadlock), 0);

        io_guard = '1;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("pre_reset_steps", 32'(io_steps), 9);
        chk("pre_reset_en_a", 32'(io_en_a), 9);
        reset = 1'b1;
        io_start = 1'b1;
        tick();
        reset = 1'b0;
        io_start = 1'b0;
        chk("rst_state", 32'(io_state), 0);
        chk("rst_steps", 32'(io_steps), 0);
        chk("rst_en_a", 32'(io_en_a), 31);
        chk("rst_fire", 32'(io_fire), 0);
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
        chk("rst_next_run_en_a", 32'(io_en_a), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
